controle_calc: RTL and testbench
================================

# controle_calc

Multi-cycle instruction sequencer that sits directly upstream of the 4-entry, 32-bit register bank (BancoReg). It accepts one 16-bit calculator instruction per handshake and decodes it. It drives the bank's read selects and captures both operands, runs them through an internal ALU, then drives the bank's write port with the result. It is the control/execute stage of the MIPS calculator datapath.

## Interface
Parameters:
- LARGURA, 32, data width; must match the register bank.
- LARG_ID, 2, register index width (4 registers).

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Instrucao  in  16  instruction word: [15:12] op, [11:10] rd, [9:8] rs, [7:6] rt, [5:0] imm (signed).
- InstrValido  in  1  upstream asserts when Instrucao is valid.
- InstrPronto  out  1  block can accept; a transfer occurs on a rising edge with InstrValido && InstrPronto.
- Fonte1, Fonte2  out  LARG_ID  read selects to the register bank.
- DadoLido1, DadoLido2  in  LARGURA  read data from the register bank.
- IdReg  out  LARG_ID  write select to the register bank.
- Escrita  out  1  write enable to the register bank.
- Dado  out  LARGURA  write data to the register bank.
- Resultado  out  LARGURA  last computed result, held until the next completion.
- Concluido  out  1  one-cycle pulse when an instruction retires.
- Erro  out  1  one-cycle pulse when an illegal opcode retires.
- Overflow  out  1  signed overflow flag of the last ADD/SUB/ADDI; held.

## Operation
- Opcodes:
  - 0 ADD: rs+rt
  - 1 SUB: rs−rt
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLT: signed, result 1/0
  - 6 ADDI: rs+sext(imm)
  - 7 LI: sext(imm)
  - 8 NOP: no write
  - 9–15: illegal
- FSM states: OCIOSO, DECODIFICA, EXECUTA, ESCREVE.
- OCIOSO:
  - InstrPronto=1.
  - On handshake, latch Instrucao into an internal register and go to DECODIFICA.
- DECODIFICA:
  - Drive Fonte1=rs, Fonte2=rt.
  - Illegal op: pulse Erro and Concluido, no write, go to OCIOSO.
  - Otherwise go to EXECUTA.
- EXECUTA:
  - Keep Fonte1/Fonte2 stable.
  - Register the ALU output of DadoLido1/DadoLido2 (or imm) into the result register.
  - Update Overflow only for ops 0, 1, 6; other ops leave it unchanged.
  - Go to ESCREVE.
- ESCREVE:
  - Escrita=1 (0 for NOP), IdReg=rd, Dado=result.
  - Update Resultado (not for NOP).
  - Pulse Concluido, go to OCIOSO.
- Arithmetic is LARGURA-bit two's complement, wrapping. imm is sign-extended from 6 bits (range −32..31).
- Overflow rule: operands of equal sign whose result has the opposite sign (ADD/ADDI). For SUB: operands of opposite sign whose result sign differs from rs.
- rd may equal rs/rt. The next instruction reads the new value, because it cannot reach DECODIFICA before the write cycle completes.

## Timing
- Reset values:
  - State OCIOSO.
  - InstrPronto=1.
  - Escrita=0, Concluido=0, Erro=0, Overflow=0.
  - Fonte1/Fonte2/IdReg=0.
  - Dado=0, Resultado=0.
- Reset asserted mid-instruction: immediate abort. Escrita drops asynchronously, no write occurs, and the instruction is lost.
- Latency, accept edge → Concluido: 3 cycles (DECODIFICA, EXECUTA, ESCREVE). Illegal op: 1 cycle.
- Throughput: one instruction per 4 cycles. InstrPronto is low outside OCIOSO.
- InstrValido while busy: not accepted. Upstream must hold Instrucao stable until the handshake.
- Escrita is high for exactly one full cycle (ESCREVE), with IdReg/Dado stable for that whole cycle. This makes it compatible with the bank writing on either clock edge.
- The bank's DadoLido may settle anywhere within DECODIFICA. It is sampled at the rising edge ending EXECUTA.

## Structure
- Package calc_pkg holds:
  - opcode localparams OP_ADD..OP_NOP;
  - state encoding;
  - instruction field bit positions;
  - LARGURA/LARG_ID defaults.
- Sub-module ula_calc: purely combinational ALU (op, a, b → resultado, overflow). It is instantiated once inside controle_calc.
- FSM, instruction latch, and output registers live in controle_calc.

## Test plan
- **Reset:** Reset low mid-EXECUTA → all outputs at reset values, no Escrita pulse; after release, InstrPronto=1.
- **LI and ADD:**
  - LI r0,#5, then LI r1,#−3 → bank r0=5, r1=0xFFFFFFFD.
  - ADD r2,r0,r1 → Dado=2 and Concluido exactly 3 cycles after accept; Overflow=0.
- **Overflow:**
  - Preload r0=0x7FFFFFFF. ADDI r3,r0,#1 → r3=0x80000000, Overflow=1.
  - SUB r3,r1,r1 (r1=0xFFFFFFFD) → r3=0, Overflow=0.
- **SLT:** r0=−1, r1=1: SLT r2,r0,r1 → 1; SLT r2,r1,r0 → 0.
- **Illegal, NOP and busy:**
  - Opcode 0xC → Erro and Concluido pulse 1 cycle after accept, Escrita never high.
  - NOP → Concluido, Escrita=0, Resultado unchanged.
  - InstrValido held during busy → exactly one accept per 4 cycles.
- **Hazard:** ADDI r1,r1,#1 issued back-to-back 3 times from r1=0 → r1=3 at the end.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator control/execute stage: opcodes,
// FSM encoding and instruction field positions.
package calc_pkg;

  localparam int LARGURA_DEF = 32;
  localparam int LARG_ID_DEF = 2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_LI   = 4'd7;
  localparam logic [3:0] OP_NOP  = 4'd8;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int RT_MSB  = 7;
  localparam int RT_LSB  = 6;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    DECODIFICA = 2'd1,
    EXECUTA    = 2'd2,
    ESCREVE    = 2'd3
  } estado_t;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_NOP;
  endfunction

endpackage

// File: rtl/ula_calc.sv
// Combinational ALU: b already carries the sign-extended immediate for
// ADDI/LI, so LI simply forwards b.
module ula_calc
  import calc_pkg::*;
#(
  parameter int LARGURA = LARGURA_DEF
) (
  input  logic [3:0]         op,
  input  logic [LARGURA-1:0] a,
  input  logic [LARGURA-1:0] b,
  output logic [LARGURA-1:0] resultado,
  output logic               overflow
);

  localparam int M = LARGURA - 1;

  logic [LARGURA-1:0] soma, dif;

  assign soma = a + b;
  assign dif  = a - b;

  always_comb begin
    resultado = '0;
    overflow  = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        resultado = soma;
        overflow  = (a[M] == b[M]) && (soma[M] != a[M]);
      end
      OP_SUB: begin
        resultado = dif;
        overflow  = (a[M] != b[M]) && (dif[M] != a[M]);
      end
      OP_AND: resultado = a & b;
      OP_OR:  resultado = a | b;
      OP_XOR: resultado = a ^ b;
      OP_SLT: resultado[0] = $signed(a) < $signed(b);
      OP_LI:  resultado = b;
      default: ;
    endcase
  end

endmodule

// File: rtl/controle_calc.sv
// Four-state sequencer: latch instruction, read bank, execute in ula_calc,
// then drive the bank write port for exactly one cycle.
module controle_calc
  import calc_pkg::*;
#(
  parameter int LARGURA = LARGURA_DEF,
  parameter int LARG_ID = LARG_ID_DEF
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [15:0]        Instrucao,
  input  logic               InstrValido,
  output logic               InstrPronto,
  output logic [LARG_ID-1:0] Fonte1,
  output logic [LARG_ID-1:0] Fonte2,
  input  logic [LARGURA-1:0] DadoLido1,
  input  logic [LARGURA-1:0] DadoLido2,
  output logic [LARG_ID-1:0] IdReg,
  output logic               Escrita,
  output logic [LARGURA-1:0] Dado,
  output logic [LARGURA-1:0] Resultado,
  output logic               Concluido,
  output logic               Erro,
  output logic               Overflow
);

  estado_t            estado_q, estado_d;
  logic [15:0]        instr_q;
  logic [LARGURA-1:0] res_q;
  logic               ov_q;

  logic [3:0]         op;
  logic [LARGURA-1:0] imm_ext, op_b, ula_res;
  logic               ula_ov, usa_imm, atualiza_ov;

  assign op          = instr_q[OP_MSB:OP_LSB];
  assign imm_ext     = {{(LARGURA-IMM_W){instr_q[IMM_MSB]}}, instr_q[IMM_MSB:IMM_LSB]};
  assign usa_imm     = (op == OP_ADDI) || (op == OP_LI);
  assign op_b        = usa_imm ? imm_ext : DadoLido2;
  assign atualiza_ov = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);

  ula_calc #(.LARGURA(LARGURA)) u_ula (
    .op        (op),
    .a         (DadoLido1),
    .b         (op_b),
    .resultado (ula_res),
    .overflow  (ula_ov)
  );

  // Selects come straight from the latched word, so they stay stable
  // through DECODIFICA and EXECUTA without extra registers.
  assign Fonte1    = LARG_ID'(instr_q[RS_MSB:RS_LSB]);
  assign Fonte2    = LARG_ID'(instr_q[RT_MSB:RT_LSB]);
  assign IdReg     = LARG_ID'(instr_q[RD_MSB:RD_LSB]);
  assign Dado      = res_q;
  assign Resultado = res_q;
  assign Overflow  = ov_q;

  always_comb begin
    estado_d    = estado_q;
    InstrPronto = 1'b0;
    Escrita     = 1'b0;
    Concluido   = 1'b0;
    Erro        = 1'b0;
    case (estado_q)
      OCIOSO: begin
        InstrPronto = 1'b1;
        if (InstrValido) estado_d = DECODIFICA;
      end
      DECODIFICA: begin
        if (op_legal(op)) begin
          estado_d = EXECUTA;
        end else begin
          Erro      = 1'b1;
          Concluido = 1'b1;
          estado_d  = OCIOSO;
        end
      end
      EXECUTA: estado_d = ESCREVE;
      ESCREVE: begin
        Escrita   = (op != OP_NOP);
        Concluido = 1'b1;
        estado_d  = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      estado_q <= OCIOSO;
      instr_q  <= '0;
      res_q    <= '0;
      ov_q     <= 1'b0;
    end else begin
      estado_q <= estado_d;
      if (estado_q == OCIOSO && InstrValido) instr_q <= Instrucao;
      // Result lands on the edge entering ESCREVE so Dado/Resultado are
      // valid for the whole write cycle; NOP keeps the previous result.
      if (estado_q == EXECUTA) begin
        if (op != OP_NOP) res_q <= ula_res;
        if (atualiza_ov)  ov_q  <= ula_ov;
      end
    end
  end

endmodule

// File: tb/tb_controle_calc.sv
// Directed bench for controle_calc acting as the register bank, with a
// scoreboard of expected retirements.
module tb_controle_calc;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] Instrucao;
  logic        InstrValido;
  logic        InstrPronto;
  logic [1:0]  Fonte1, Fonte2, IdReg;
  logic [31:0] DadoLido1, DadoLido2, Dado, Resultado;
  logic        Escrita, Concluido, Erro, Overflow;

  logic [31:0] bank [4];

  typedef struct {
    logic [31:0] dado;
    logic [1:0]  id;
    logic        wr;
    logic        erro;
    logic        ov;
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        exp_ov = 1'b0;
  logic [31:0] exp_res = '0;

  assign DadoLido1 = bank[Fonte1];
  assign DadoLido2 = bank[Fonte2];

  controle_calc #(.LARGURA(32), .LARG_ID(2)) dut (
    .Clock(Clock), .Reset(Reset), .Instrucao(Instrucao), .InstrValido(InstrValido),
    .InstrPronto(InstrPronto), .Fonte1(Fonte1), .Fonte2(Fonte2),
    .DadoLido1(DadoLido1), .DadoLido2(DadoLido2), .IdReg(IdReg), .Escrita(Escrita),
    .Dado(Dado), .Resultado(Resultado), .Concluido(Concluido), .Erro(Erro),
    .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic ovf(input longint v);
    return (v > 64'sd2147483647) || (v < -64'sd2147483648);
  endfunction

  task automatic wait_pronto();
    int t = 0;
    while (!InstrPronto && t < 20) begin
      @(negedge Clock);
      t++;
    end
    chk("pronto_wait", {31'd0, InstrPronto}, 32'd1);
  endtask

  // Issue one instruction, push its expected retirement, and wait for it.
  task automatic run(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                     input logic [1:0] rt, input logic [5:0] imm, input string tag);
    exp_t        e, g;
    logic [31:0] a, b, r, immx;
    logic        ov;
    bit          done;
    int          lat;
    a    = bank[rs];
    b    = bank[rt];
    immx = 32'($signed(imm));
    r    = exp_res;
    ov   = exp_ov;
    case (op)
      4'd0: begin r = a + b;    ov = ovf(longint'($signed(a)) + longint'($signed(b))); end
      4'd1: begin r = a - b;    ov = ovf(longint'($signed(a)) - longint'($signed(b))); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: begin r = a + immx; ov = ovf(longint'($signed(a)) + longint'($signed(immx))); end
      4'd7: r = immx;
      default: ;
    endcase
    e.wr   = (op <= 4'd7);
    e.erro = (op > 4'd8);
    e.lat  = e.erro ? 1 : 3;
    e.dado = r;
    e.id   = rd;
    e.ov   = ov;
    e.res  = e.wr ? r : exp_res;
    exp_res = e.res;
    exp_ov  = ov;

    wait_pronto();
    Instrucao   = {op, rd, rs, rt, imm};
    InstrValido = 1'b1;
    @(posedge Clock);
    #1 InstrValido = 1'b0;
    sb.push_back(e);

    done = 1'b0;
    lat  = 0;
    while (!done && lat < 8) begin
      @(negedge Clock);
      lat++;
      if (Concluido) begin
        done = 1'b1;
        if (sb.size() == 0) begin
          chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
          g = sb.pop_front();
          chk({tag, "_lat"},     lat, g.lat);
          chk({tag, "_escrita"}, {31'd0, Escrita}, {31'd0, g.wr});
          chk({tag, "_erro"},    {31'd0, Erro}, {31'd0, g.erro});
          chk({tag, "_ovf"},     {31'd0, Overflow}, {31'd0, g.ov});
          chk({tag, "_res"},     Resultado, g.res);
          if (g.wr) begin
            chk({tag, "_dado"},  Dado, g.dado);
            chk({tag, "_idreg"}, {30'd0, IdReg}, {30'd0, g.id});
          end
        end
        if (Escrita) bank[IdReg] = Dado;
      end else begin
        chk({tag, "_early_escrita"}, {31'd0, Escrita}, 32'd0);
      end
    end
    if (!done) chk({tag, "_timeout"}, {31'd0, Concluido}, 32'd1);
  endtask

  initial begin
    int acc, last;
    for (int i = 0; i < 4; i++) bank[i] = '0;
    Reset       = 1'b0;
    InstrValido = 1'b0;
    Instrucao   = '0;
    repeat (3) @(negedge Clock);
    chk("rst_pronto",    {31'd0, InstrPronto}, 32'd1);
    chk("rst_escrita",   {31'd0, Escrita}, 32'd0);
    chk("rst_concluido", {31'd0, Concluido}, 32'd0);
    chk("rst_dado",      Resultado, 32'd0);
    Reset = 1'b1;
    @(negedge Clock);

    // LI and ADD
    run(4'd7, 2'd0, 2'd0, 2'd0, 6'd5,  "li_r0");
    chk("bank_r0", bank[0], 32'd5);
    run(4'd7, 2'd1, 2'd0, 2'd0, 6'h3D, "li_r1");
    chk("bank_r1", bank[1], 32'hFFFF_FFFD);
    run(4'd0, 2'd2, 2'd0, 2'd1, 6'd0,  "add");
    chk("bank_r2", bank[2], 32'd2);

    // Overflow
    bank[0] = 32'h7FFF_FFFF;
    run(4'd6, 2'd3, 2'd0, 2'd0, 6'd1,  "addi_ovf");
    chk("bank_r3_ovf", bank[3], 32'h8000_0000);
    chk("ovf_set", {31'd0, Overflow}, 32'd1);
    run(4'd4, 2'd2, 2'd0, 2'd1, 6'd0,  "xor_ovf_held");
    run(4'd1, 2'd3, 2'd1, 2'd1, 6'd0,  "sub_zero");
    chk("bank_r3_zero", bank[3], 32'd0);

    // SLT, AND, OR
    bank[0] = 32'hFFFF_FFFF;
    bank[1] = 32'd1;
    run(4'd5, 2'd2, 2'd0, 2'd1, 6'd0,  "slt_true");
    chk("slt_true_bank", bank[2], 32'd1);
    run(4'd5, 2'd2, 2'd1, 2'd0, 6'd0,  "slt_false");
    chk("slt_false_bank", bank[2], 32'd0);
    run(4'd2, 2'd3, 2'd0, 2'd1, 6'd0,  "and");
    run(4'd3, 2'd3, 2'd1, 2'd2, 6'd0,  "or");

    // Illegal and NOP
    run(4'hC, 2'd1, 2'd0, 2'd0, 6'd0,  "illegal");
    chk("illegal_nowrite", bank[1], 32'd1);
    run(4'd8, 2'd0, 2'd0, 2'd0, 6'd0,  "nop");
    chk("nop_nowrite", bank[0], 32'hFFFF_FFFF);

    // InstrValido held while busy: one accept every 4 cycles
    wait_pronto();
    Instrucao   = {4'd7, 2'd2, 2'd0, 2'd0, 6'd7};
    InstrValido = 1'b1;
    acc  = 0;
    last = 0;
    for (int i = 0; i < 12; i++) begin
      if (InstrPronto) begin
        if (acc > 0) chk("busy_gap", i - last, 4);
        acc++;
        last = i;
      end
      if (Escrita) begin
        chk("busy_dado", Dado, 32'd7);
        bank[IdReg] = Dado;
      end
      if (i == 11) InstrValido = 1'b0;
      @(negedge Clock);
    end
    chk("busy_accepts", acc, 3);
    exp_res = 32'd7;

    // Read-after-write across back-to-back instructions
    run(4'd7, 2'd1, 2'd0, 2'd0, 6'd0,  "li_r1_zero");
    for (int k = 0; k < 3; k++) run(4'd6, 2'd1, 2'd1, 2'd0, 6'd1, "addi_hazard");
    chk("hazard_r1", bank[1], 32'd3);

    // Reset in EXECUTA with Overflow and Resultado non-zero
    bank[0] = 32'h7FFF_FFFF;
    run(4'd6, 2'd3, 2'd0, 2'd0, 6'd1,  "addi_pre_rst");
    wait_pronto();
    Instrucao   = {4'd0, 2'd2, 2'd0, 2'd1, 6'd0};
    InstrValido = 1'b1;
    @(posedge Clock);
    #1 InstrValido = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("mid_rst_pronto",  {31'd0, InstrPronto}, 32'd1);
    chk("mid_rst_escrita", {31'd0, Escrita}, 32'd0);
    chk("mid_rst_ovf",     {31'd0, Overflow}, 32'd0);
    chk("mid_rst_res",     Resultado, 32'd0);
    chk("mid_rst_dado",    Dado, 32'd0);
    chk("mid_rst_sel",     {26'd0, Fonte1, Fonte2, IdReg}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk("mid_rst_quiet", {30'd0, Escrita, Concluido}, 32'd0);
    end
    Reset = 1'b1;
    @(negedge Clock);
    chk("post_rst_pronto", {31'd0, InstrPronto}, 32'd1);
    chk("post_rst_escrita", {31'd0, Escrita}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
